// File: rtl/bus_resp_pkg.sv
// Shared types and constants for the multiplexed-bus memory responder.
// Lane codes are the raw {A0, BHE#} pair so decode is a direct lookup.
package bus_resp_pkg;

   localparam int ADDR_W = 20;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      RD_ISSUE,
      RD_CAP1,
      RD_CAP2,
      RD_HOLD,
      WR_ISSUE,
      WR_HI,
      WR_HOLD
   } state_t;

   typedef logic [1:0] lane_t;

   localparam lane_t LANE_WORD = 2'b00;
   localparam lane_t LANE_LO   = 2'b01;
   localparam lane_t LANE_HI   = 2'b10;
   localparam lane_t LANE_NONE = 2'b11;

endpackage

// File: rtl/bus_lane_dec.sv
// Combinational byte-lane decode from {A0, BHE#} plus the byte addresses
// of the first and (word-only) second lane access.
module bus_lane_dec #(
   parameter int ADDR_W = bus_resp_pkg::ADDR_W
) (
   input  logic [ADDR_W-1:0]  addr,
   input  logic               bhe_n,
   output bus_resp_pkg::lane_t lane,
   output logic [ADDR_W-1:0]  addr_first,
   output logic [ADDR_W-1:0]  addr_second
);
   import bus_resp_pkg::*;

   always_comb begin
      lane = LANE_NONE;
      case ({addr[0], bhe_n})
         2'b00:   lane = LANE_WORD;
         2'b01:   lane = LANE_LO;
         2'b10:   lane = LANE_HI;
         default: lane = LANE_NONE;
      endcase
   end

   // A word is only decoded at an even address, so addr|1 never wraps.
   assign addr_first  = addr;
   assign addr_second = addr | {{(ADDR_W-1){1'b0}}, 1'b1};

endmodule

// File: rtl/bus_mem_responder.sv
// Memory-side responder for an 8086-style minimum-mode multiplexed bus:
// latches the address on ALE, splits the cycle into byte-wide RAM accesses.
module bus_mem_responder #(
   parameter int ADDR_W = 20,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ale,
   input  logic              rd_n,
   input  logic              wr_n,
   input  logic              m_io,
   input  logic              bhe_n,
   input  logic [15:0]       ad_in,
   input  logic [3:0]        as_in,
   output logic [15:0]       ad_out,
   output logic              ad_oe,
   output logic              ready,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_rd_addr,
   input  logic [7:0]        ram_rd_data,
   output logic              ram_wr_en,
   output logic              ram_wr_we,
   output logic [ADDR_W-1:0] ram_wr_addr,
   output logic [7:0]        ram_wr_data
);
   import bus_resp_pkg::*;

   // The capture states assume read data one cycle after the enable.
   generate
      if (RD_LAT != 1) begin : g_rd_lat_check
         $error("bus_mem_responder supports RD_LAT == 1 only");
      end
   endgenerate

   state_t            state;
   logic [ADDR_W-1:0] addr_reg;
   logic              bhe_l;
   logic              mem_l;
   logic [15:0]       data_reg;

   lane_t             lane;
   logic [ADDR_W-1:0] addr_first;
   logic [ADDR_W-1:0] addr_second;

   bus_lane_dec #(.ADDR_W(ADDR_W)) u_lane_dec (
      .addr        (addr_reg),
      .bhe_n       (bhe_l),
      .lane        (lane),
      .addr_first  (addr_first),
      .addr_second (addr_second)
   );

   assign ram_wr_we = ram_wr_en;

   // RAM strobes are registered from the next state, so each strobe is high
   // during the state that owns that access.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         addr_reg    <= '0;
         bhe_l       <= 1'b1;
         mem_l       <= 1'b0;
         data_reg    <= '0;
         ad_out      <= '0;
         ad_oe       <= 1'b0;
         ready       <= 1'b1;
         ram_rd_en   <= 1'b0;
         ram_rd_addr <= '0;
         ram_wr_en   <= 1'b0;
         ram_wr_addr <= '0;
         ram_wr_data <= '0;
      end else begin
         ram_rd_en <= 1'b0;
         ram_wr_en <= 1'b0;
         if (ale) begin
            addr_reg <= {as_in, ad_in};
            bhe_l    <= bhe_n;
            mem_l    <= m_io;
            state    <= ADDR;
            ad_oe    <= 1'b0;
            ad_out   <= '0;
            ready    <= 1'b1;
         end else begin
            case (state)
               IDLE: ;
               ADDR: begin
                  // I/O cycles, lane code 11 and ambiguous strobes never touch RAM.
                  if (mem_l && lane != LANE_NONE && (rd_n ^ wr_n)) begin
                     ready <= 1'b0;
                     if (!rd_n) begin
                        state       <= RD_ISSUE;
                        data_reg    <= '0;
                        ram_rd_en   <= 1'b1;
                        ram_rd_addr <= addr_first;
                     end else begin
                        state       <= WR_ISSUE;
                        data_reg    <= ad_in;
                        ram_wr_en   <= 1'b1;
                        ram_wr_addr <= addr_first;
                        ram_wr_data <= (lane == LANE_HI) ? ad_in[15:8] : ad_in[7:0];
                     end
                  end
               end
               RD_ISSUE: begin
                  state <= RD_CAP1;
                  if (lane == LANE_WORD) begin
                     ram_rd_en   <= 1'b1;
                     ram_rd_addr <= addr_second;
                  end
               end
               RD_CAP1: begin
                  if (lane == LANE_WORD) begin
                     data_reg[7:0] <= ram_rd_data;
                     state         <= RD_CAP2;
                  end else begin
                     state  <= RD_HOLD;
                     ready  <= 1'b1;
                     ad_oe  <= 1'b1;
                     ad_out <= (lane == LANE_HI) ? {ram_rd_data, 8'h00}
                                                 : {8'h00, ram_rd_data};
                  end
               end
               RD_CAP2: begin
                  state  <= RD_HOLD;
                  ready  <= 1'b1;
                  ad_oe  <= 1'b1;
                  ad_out <= {ram_rd_data, data_reg[7:0]};
               end
               RD_HOLD: begin
                  if (rd_n) begin
                     state  <= IDLE;
                     ad_oe  <= 1'b0;
                     ad_out <= '0;
                  end
               end
               WR_ISSUE: begin
                  if (lane == LANE_WORD) begin
                     state       <= WR_HI;
                     ram_wr_en   <= 1'b1;
                     ram_wr_addr <= addr_second;
                     ram_wr_data <= data_reg[15:8];
                  end else begin
                     state <= WR_HOLD;
                     ready <= 1'b1;
                  end
               end
               WR_HI: begin
                  state <= WR_HOLD;
                  ready <= 1'b1;
               end
               WR_HOLD: begin
                  if (wr_n) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder with a byte-wide RAM model that
// returns read data one cycle after the enable.
module tb_bus_mem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ale = 1'b0;
   logic        rd_n = 1'b1;
   logic        wr_n = 1'b1;
   logic        m_io = 1'b1;
   logic        bhe_n = 1'b1;
   logic [15:0] ad_in = '0;
   logic [3:0]  as_in = '0;
   logic [15:0] ad_out;
   logic        ad_oe;
   logic        ready;
   logic        ram_rd_en;
   logic [19:0] ram_rd_addr;
   logic [7:0]  ram_rd_data = '0;
   logic        ram_wr_en;
   logic        ram_wr_we;
   logic [19:0] ram_wr_addr;
   logic [7:0]  ram_wr_data;

   int n_assert = 0;
   int n_fail   = 0;

   logic       preload = 1'b1;
   logic [7:0] mem [0:(1<<20)-1];

   always #5 clk = ~clk;

   bus_mem_responder #(.ADDR_W(20), .RD_LAT(1)) dut (
      .clk         (clk),
      .rst         (rst),
      .ale         (ale),
      .rd_n        (rd_n),
      .wr_n        (wr_n),
      .m_io        (m_io),
      .bhe_n       (bhe_n),
      .ad_in       (ad_in),
      .as_in       (as_in),
      .ad_out      (ad_out),
      .ad_oe       (ad_oe),
      .ready       (ready),
      .ram_rd_en   (ram_rd_en),
      .ram_rd_addr (ram_rd_addr),
      .ram_rd_data (ram_rd_data),
      .ram_wr_en   (ram_wr_en),
      .ram_wr_we   (ram_wr_we),
      .ram_wr_addr (ram_wr_addr),
      .ram_wr_data (ram_wr_data)
   );

   always @(posedge clk) begin
      if (preload) begin
         mem[20'h12340] <= 8'hCD;
         mem[20'h12341] <= 8'hAB;
         mem[20'h00051] <= 8'h5A;
         mem[20'h00100] <= 8'h11;
         mem[20'h00101] <= 8'h22;
         mem[20'h00200] <= 8'h77;
         mem[20'h00201] <= 8'h66;
      end else if (ram_wr_en) begin
         mem[ram_wr_addr] <= ram_wr_data;
      end
      if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_ale(input logic [3:0] a_hi, input logic [15:0] a_lo,
                         input logic bhe, input logic mio);
      ale   = 1'b1;
      as_in = a_hi;
      ad_in = a_lo;
      bhe_n = bhe;
      m_io  = mio;
      tick();
      ale   = 1'b0;
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      chk("rst_ready", ready, 1);
      chk("rst_ad_oe", ad_oe, 0);
      chk("rst_ad_out", ad_out, 0);
      chk("rst_rd_en", ram_rd_en, 0);
      chk("rst_wr_en", ram_wr_en, 0);
      chk("rst_wr_we", ram_wr_we, 0);
      chk("rst_rd_addr", ram_rd_addr, 0);
      chk("rst_wr_addr", ram_wr_addr, 0);
      chk("rst_wr_data", ram_wr_data, 0);
      preload = 1'b0;
      rst = 1'b1;
      tick();
      $display("txn reset released");

      // Word read at 0x12340: ready rises on the 4th edge after rd_n=0 is sampled
      do_ale(4'h1, 16'h2340, 1'b0, 1'b1);
      chk("wrd_addr_ready", ready, 1);
      rd_n = 1'b0;
      tick();
      chk("wrd_c1_ready", ready, 0);
      chk("wrd_c1_rd_en", ram_rd_en, 1);
      chk("wrd_c1_rd_addr", ram_rd_addr, 20'h12340);
      tick();
      chk("wrd_c2_ready", ready, 0);
      chk("wrd_c2_rd_en", ram_rd_en, 1);
      chk("wrd_c2_rd_addr", ram_rd_addr, 20'h12341);
      tick();
      chk("wrd_c3_ready", ready, 0);
      chk("wrd_c3_rd_en", ram_rd_en, 0);
      chk("wrd_c3_ad_oe", ad_oe, 0);
      tick();
      chk("wrd_c4_ready", ready, 1);
      chk("wrd_ad_oe", ad_oe, 1);
      chk("wrd_ad_out", ad_out, 16'hABCD);
      tick();
      chk("wrd_hold_ad_oe", ad_oe, 1);
      chk("wrd_hold_ad_out", ad_out, 16'hABCD);
      rd_n = 1'b1;
      tick();
      chk("wrd_end_ad_oe", ad_oe, 0);
      $display("txn word read 0x12340 -> 0x%04h", 16'hABCD);

      // Odd (high-lane) byte read at 0x00051: 3-cycle latency, data on AD15:8
      do_ale(4'h0, 16'h0051, 1'b0, 1'b1);
      rd_n = 1'b0;
      tick();
      chk("odd_c1_ready", ready, 0);
      chk("odd_c1_rd_addr", ram_rd_addr, 20'h00051);
      tick();
      chk("odd_c2_ready", ready, 0);
      chk("odd_c2_rd_en", ram_rd_en, 0);
      tick();
      chk("odd_c3_ready", ready, 1);
      chk("odd_ad_out", ad_out, 16'h5A00);
      chk("odd_ad_oe", ad_oe, 1);
      rd_n = 1'b1;
      tick();
      chk("odd_end_ad_oe", ad_oe, 0);
      $display("txn odd byte read 0x00051 -> 0x5A00");

      // Low-lane byte read at 0x12340 (bhe_n=1): data on AD7:0
      do_ale(4'h1, 16'h2340, 1'b1, 1'b1);
      rd_n = 1'b0;
      tick();
      tick();
      chk("lo_c2_ready", ready, 0);
      tick();
      chk("lo_c3_ready", ready, 1);
      chk("lo_ad_out", ad_out, 16'h00CD);
      rd_n = 1'b1;
      tick();
      $display("txn low byte read 0x12340 -> 0x00CD");

      // Word write 0xBEEF at 0x00100: two consecutive byte writes from latched data
      do_ale(4'h0, 16'h0100, 1'b0, 1'b1);
      wr_n  = 1'b0;
      ad_in = 16'hBEEF;
      tick();
      ad_in = 16'h0000;
      chk("ww_c1_wr_en", ram_wr_en, 1);
      chk("ww_c1_wr_we", ram_wr_we, 1);
      chk("ww_c1_wr_addr", ram_wr_addr, 20'h00100);
      chk("ww_c1_wr_data", ram_wr_data, 8'hEF);
      chk("ww_c1_ready", ready, 0);
      chk("ww_c1_rd_en", ram_rd_en, 0);
      tick();
      chk("ww_c2_wr_en", ram_wr_en, 1);
      chk("ww_c2_wr_addr", ram_wr_addr, 20'h00101);
      chk("ww_c2_wr_data", ram_wr_data, 8'hBE);
      tick();
      chk("ww_hold_wr_en", ram_wr_en, 0);
      chk("ww_hold_ready", ready, 1);
      wr_n = 1'b1;
      tick();
      chk("ww_mem_lo", mem[20'h00100], 8'hEF);
      chk("ww_mem_hi", mem[20'h00101], 8'hBE);
      $display("txn word write 0x00100 <- 0xBEEF");

      // I/O read: no RAM strobes, ready stays high
      do_ale(4'h0, 16'h0100, 1'b0, 1'b0);
      rd_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("io_ready", ready, 1);
         chk("io_rd_en", ram_rd_en, 0);
         chk("io_ad_oe", ad_oe, 0);
      end
      rd_n = 1'b1;
      tick();
      $display("txn io read ignored");

      // Lane code 11 (A0=1, bhe_n=1): no lanes, no RAM access
      do_ale(4'h0, 16'h0051, 1'b1, 1'b1);
      rd_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("none_ready", ready, 1);
         chk("none_rd_en", ram_rd_en, 0);
         chk("none_ad_oe", ad_oe, 0);
         chk("none_ad_out", ad_out, 0);
      end
      rd_n = 1'b1;
      tick();
      $display("txn lane-11 read completes with no access");

      // Reset asserted during WR_HI: high byte write must not land
      do_ale(4'h0, 16'h0100, 1'b0, 1'b1);
      wr_n  = 1'b0;
      ad_in = 16'h1234;
      tick();
      tick();
      chk("rmw_whi_wr_en", ram_wr_en, 1);
      chk("rmw_whi_wr_addr", ram_wr_addr, 20'h00101);
      #2;
      rst = 1'b0;
      #1;
      chk("rmw_wr_en", ram_wr_en, 0);
      chk("rmw_ready", ready, 1);
      chk("rmw_ad_oe", ad_oe, 0);
      wr_n = 1'b1;
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("rmw_mem_lo", mem[20'h00100], 8'h34);
      chk("rmw_mem_hi", mem[20'h00101], 8'hBE);
      $display("txn reset during word write 0x00100");

      // New ALE while a read is held: ad_oe drops, new read returns fresh data
      do_ale(4'h1, 16'h2340, 1'b0, 1'b1);
      rd_n = 1'b0;
      tick();
      tick();
      tick();
      tick();
      chk("abort_pre_ad_oe", ad_oe, 1);
      do_ale(4'h0, 16'h0200, 1'b0, 1'b1);
      chk("abort_ad_oe", ad_oe, 0);
      chk("abort_ready", ready, 1);
      tick();
      chk("abort_c1_ready", ready, 0);
      chk("abort_c1_rd_addr", ram_rd_addr, 20'h00200);
      tick();
      tick();
      tick();
      chk("abort_c4_ready", ready, 1);
      chk("abort_ad_out", ad_out, 16'h6677);
      chk("abort_c4_ad_oe", ad_oe, 1);
      rd_n = 1'b1;
      tick();
      chk("abort_end_ad_oe", ad_oe, 0);
      $display("txn ale during hold, read 0x00200 -> 0x6677");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
